// File: rtl/gray_counter.sv
// gray_counter: registered up/down binary counter with a Gray-coded mirror.
// Both codes are registered on the same edge, which keeps the Gray output
// glitch-free and usable as a clock-domain-crossing pointer. Supports a
// parallel load in binary or Gray, and wrap or saturate at the range limits.
module gray_counter #(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [WIDTH-1:0] gray_bin;
  logic [WIDTH-1:0] bin_next;
  logic             tc_next;
  logic             at_limit;

  // Gray-to-binary of the load value: binary bit i is the XOR of Gray bits i and above
  always_comb begin
    gray_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gray_bin[i] = ^(load_val >> i);
    end
  end

  // The limit depends on the direction: all-ones counting up, zero counting down
  assign at_limit = up ? (bin_out == MAX_VAL) : (bin_out == '0);

  // Next-state selection in priority order: load, then count, otherwise hold
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch is inferred.
    bin_next = bin_out;
    tc_next  = 1'b0;
    if (load) begin
      bin_next = load_is_gray ? gray_bin : load_val;
    end else if (en) begin
      tc_next = at_limit;
      // In saturate mode a count at the limit leaves the value where it is
      if (!at_limit || WRAP) begin
        bin_next = up ? bin_out + 1'b1 : bin_out - 1'b1;
      end
    end
  end

  // Output registers: binary, Gray and terminal count all update on the same edge
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every register samples pre-edge values.
    if (rst) begin
      bin_out  <= '0;
      gray_out <= '0;
      tc       <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= bin_next ^ (bin_next >> 1);
      tc       <= tc_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed and randomized checks of gray_counter in both
// boundary modes against an integer behavioural model.
module tb_gray_counter;

  localparam int W       = 4;
  localparam int MAX_INT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic         load_is_gray;
  logic [W-1:0] load_val;

  logic [W-1:0] bin0, gray0, bin1, gray1;
  logic         tc0, tc1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_out(bin0), .gray_out(gray0), .tc(tc0)
  );

  gray_counter #(.WIDTH(W), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_out(bin1), .gray_out(gray1), .tc(tc1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray decode walking from the MSB down, on plain integers
  function automatic int gray_to_bin(input int g);
    int b = 0;
    bit acc = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic int model_next(input int v, input bit wrap, input bit l, input bit lg,
                                    input int lv, input bit e, input bit u);
    if (l) return lg ? gray_to_bin(lv) : lv;
    if (!e) return v;
    if (u) return (v == MAX_INT) ? (wrap ? 0 : v) : v + 1;
    return (v == 0) ? (wrap ? MAX_INT : 0) : v - 1;
  endfunction

  function automatic bit model_tc(input int v, input bit l, input bit e, input bit u);
    return !l && e && (u ? (v == MAX_INT) : (v == 0));
  endfunction

  int           m_wrap = 0;
  int           m_sat  = 0;
  bit           mt_wrap = 1'b0;
  bit           mt_sat  = 1'b0;
  bit           m_counted = 1'b0;
  logic [W-1:0] prev_gray = '0;

  // Reference model advance
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wrap    <= 0;
      m_sat     <= 0;
      mt_wrap   <= 1'b0;
      mt_sat    <= 1'b0;
      m_counted <= 1'b0;
    end else begin
      m_wrap    <= model_next(m_wrap, 1'b1, load, load_is_gray, int'(load_val), en, up);
      m_sat     <= model_next(m_sat, 1'b0, load, load_is_gray, int'(load_val), en, up);
      mt_wrap   <= model_tc(m_wrap, load, en, up);
      mt_sat    <= model_tc(m_sat, load, en, up);
      m_counted <= en && !load;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("wrap_bin", 32'(bin0), m_wrap);
    check("wrap_gray", 32'(gray0), m_wrap ^ (m_wrap >> 1));
    check("wrap_tc", 32'(tc0), 32'(mt_wrap));
    check("sat_bin", 32'(bin1), m_sat);
    check("sat_gray", 32'(gray1), m_sat ^ (m_sat >> 1));
    check("sat_tc", 32'(tc1), 32'(mt_sat));
    if (m_counted) check("one_bit_step", $countones(gray0 ^ prev_gray), 1);
    prev_gray <= gray0;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] gseq [17];

  initial begin
    gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
             4'b0000};
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_is_gray = 1'b0; load_val = '0;
    tick();
    tick();

    // Reset release, then hold
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_bin", 32'(bin0), 0);
      check("hold_gray", 32'(gray0), 0);
      check("hold_tc", 32'(tc0), 0);
    end

    // Full up count with wrap
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("up_gray_seq", 32'(gray0), 32'(gseq[i]));
      check("up_tc", 32'(tc0), (i == 16) ? 1 : 0);
    end

    // Count to 6, then asynchronous reset mid-cycle
    for (int i = 0; i < 6; i++) tick();
    check("count_to_6", 32'(bin0), 6);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bin", 32'(bin0), 0);
    check("async_rst_gray", 32'(gray0), 0);
    check("async_rst_tc", 32'(tc0), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_bin", 32'(bin0), 1);
    check("post_rst_gray", 32'(gray0), 1);

    // Down wrap from zero
    rst = 1'b1;
    tick();
    rst = 1'b0; up = 1'b0;
    tick();
    check("down_wrap_bin", 32'(bin0), 15);
    check("down_wrap_gray", 32'(gray0), 8);
    check("down_wrap_tc", 32'(tc0), 1);
    check("down_sat_bin", 32'(bin1), 0);
    check("down_sat_tc", 32'(tc1), 1);
    tick();
    check("down_next_bin", 32'(bin0), 14);
    check("down_next_gray", 32'(gray0), 9);
    check("down_next_tc", 32'(tc0), 0);

    // Loads
    en = 1'b0; load = 1'b1; load_is_gray = 1'b1; load_val = 4'b1000;
    tick();
    check("gray_load_bin", 32'(bin0), 15);
    check("gray_load_gray", 32'(gray0), 8);
    load_is_gray = 1'b0; load_val = 4'b0101;
    tick();
    check("bin_load_bin", 32'(bin0), 5);
    check("bin_load_gray", 32'(gray0), 7);
    load_val = 4'b1111;
    tick();
    en = 1'b1; up = 1'b1; load_val = 4'b0011;
    tick();
    check("load_over_en_bin", 32'(bin0), 3);
    check("load_over_en_tc", 32'(tc0), 0);

    // Saturation on the non-wrapping instance
    en = 1'b0; load_val = 4'b1110;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_up_bin", 32'(bin1), 15);
      check("sat_up_tc", 32'(tc1), (i == 0) ? 0 : 1);
    end

    // Randomized traffic with direction held in bursts so both limits are reached
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 79) == 0);
      en           = ($urandom_range(0, 3) != 0);
      up           = ((i / 24) % 2) == 0;
      load         = ($urandom_range(0, 9) == 0);
      load_is_gray = 1'($urandom_range(0, 1));
      load_val     = W'($urandom);
      tick();
    end
    rst = 1'b0; en = 1'b0; load = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
# gray_counter

Parametrised, registered Gray-code counter: the sequential successor to the team's 4-bit combinational binary-to-Gray converter. It counts up or down in binary and presents the binary and Gray-coded values together from registers, so the outputs never glitch. It supports a parallel load given in either binary or Gray, wrap or saturate at the range limits, and a one-cycle terminal-count flag. It is intended for pointer generation in clock-domain-crossing FIFOs and for position or sequence counters.

## Interface
- WIDTH, 4: counter width in bits, ≥ 2.
- WRAP, 1: boundary mode. 1 = wrap around at the limits; 0 = saturate at the limits.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load; takes priority over en
- load_is_gray  input  1  1 = load_val is Gray-coded; 0 = load_val is binary
- load_val  input  WIDTH  value to load
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray count; always equals bin_out ^ (bin_out >> 1)
- tc  output  1  registered terminal-count flag; high for exactly one cycle

## Operation
- **Reset (async, rst=1):** bin_out = 0, gray_out = 0, tc = 0, immediately and independent of clk. Reset overrides load and en.
- **Per-edge priority:** rst > load > en > hold.
- **Load:**
  - If load_is_gray = 0: bin_next = load_val.
  - If load_is_gray = 1: convert Gray to binary first. b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i from WIDTH-2 down to 0.
  - tc_next = 0. en is ignored in the load cycle.
- **Count (en=1, load=0):**
  - up=1: bin_next = bin_out + 1, modulo 2^WIDTH.
  - up=0: bin_next = bin_out − 1, modulo 2^WIDTH.
- **Boundary,** defined as (up=1 and bin_out = 2^WIDTH−1) or (up=0 and bin_out = 0):
  - WRAP=1: the count wraps (max→0 or 0→max) and tc_next = 1.
  - WRAP=0: the counter holds its value and tc_next = 1. tc re-asserts on every enabled cycle spent at the boundary.
- **Non-boundary count:** tc_next = 0.
- **Hold (en=0, load=0):** bin_out and gray_out are unchanged; tc_next = 0.
- **Gray update:** gray_out is registered from bin_next ^ (bin_next >> 1) on the same edge as bin_out, so the two outputs are never mismatched.
- **Arithmetic:** all arithmetic is unsigned and WIDTH bits wide, with no carry-out port. In WRAP=1 counting, consecutive gray_out values differ in exactly one bit, including across the wrap.
- **Reset mid-operation:** asserting rst during counting or loading discards everything in flight. The first enabled edge after rst deasserts counts from 0.

## Timing
- All outputs change only on rising clk edges, except during asynchronous reset.
- Latency is one cycle. Inputs sampled at edge N appear on bin_out, gray_out and tc after edge N.
- tc is high during the cycle following the boundary count, for exactly one cycle per boundary event.
- There is no combinational path from any input to any output.
- Throughput is one count per cycle while en is held high.

## Test plan
- **Reset, then hold:** assert rst, release, keep en=0 for 3 cycles → bin_out=0000, gray_out=0000 and tc=0 throughout. Assert rst mid-cycle → outputs go to 0 before the next edge.
- **Full up count, WIDTH=4, WRAP=1:** en=1, up=1 for 16 cycles.
  - Required gray_out sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
  - tc=1 only in the cycle after the 1111→0000 step.
  - Each step must change exactly one bit.
- **Down wrap:** from reset, en=1, up=0 → bin_out=1111, gray_out=1000, tc=1 for one cycle. The next cycle gives bin_out=1110, gray_out=1001, tc=0.
- **Gray load:** load=1, load_is_gray=1, load_val=1000 → bin_out=1111, gray_out=1000.
  - Binary load of 0101 → bin_out=0101, gray_out=0111.
  - load=1 together with en=1 → the loaded value wins, tc=0.
- **Saturate, WRAP=0:** load 1110, then en=1, up=1 for 3 cycles → bin_out 1111, 1111, 1111. tc = 0, 1, 1 across those three cycles.
- **Reset mid-count:** count up to 0110, assert rst for one cycle, release with en=1 → the next edge gives bin_out=0001, gray_out=0001.
